spi_master: RTL and testbench
=============================

# spi_master

- Initiator end of the team's 40-bit SPI register protocol.
- Frame layout: one R/W flag bit (1 = write), 7-bit register address, 32-bit data, MSB first, SPI mode 0.
- Sits between on-chip control logic (sequencer, test controller) and an external or on-die spi_slave.
- Issues one frame per request and returns read data with a one-cycle completion pulse.

## Interface
Parameters:
- CLK_DIV, 4, SCLK half-period in clk cycles; must be ≥ 4 (slave oversampling requirement); elaboration fails otherwise.
- CS_SETUP, 4, clk cycles from CS_n low to first SCLK rise phase start.
- CS_IDLE, 4, minimum clk cycles CS_n stays high between frames.

Ports:
- clk  in  1  system clock; one clock, all logic on posedge.
- i_Rst_L  in  1  reset, asynchronous, active-low.
- i_Start  in  1  frame request; accepted only when o_Busy = 0.
- i_Write  in  1  1 = write frame, 0 = read frame; sampled with i_Start.
- i_Addr  in  7  register address; sampled with i_Start.
- i_Wdata  in  32  write data; sampled with i_Start, ignored for reads.
- o_Busy  out  1  high from the cycle after acceptance until the end of the CS_IDLE gap.
- o_Done  out  1  single-cycle pulse at frame end.
- o_Rdata  out  32  last read result; held until the next read completes.
- o_SPI_Clk  out  1  SCLK, idle low.
- o_SPI_MOSI  out  1  serial data out.
- o_SPI_CS_n  out  1  chip select, active low.
- i_SPI_MISO  in  1  serial data in; asynchronous, 2-flop synchronized internally.

## Operation
- Frame register loaded on acceptance:
  - Write: {1, i_Addr, i_Wdata}.
  - Read: {0, i_Addr, 32'h0}.
- States and transitions:
  - IDLE → SETUP on i_Start.
  - SETUP → SHIFT after CS_SETUP cycles.
  - SHIFT → HOLD after 40 bits.
  - HOLD → GAP after CLK_DIV cycles.
  - GAP → IDLE after CS_IDLE cycles.
- 6-bit bit counter, loaded with 39 on entry to SHIFT, decremented after each bit; frame ends when the bit with count 0 completes.
- SHIFT, per bit: CLK_DIV cycles SCLK low, then CLK_DIV cycles SCLK high.
  - MOSI changes only at the start of a low phase, so it is stable across the rising edge.
  - Synchronized MISO is shifted into the LSB of a 40-bit capture register on the last cycle of each high phase.
- Read frames: first 8 MISO bits are slave filler (1s) and are discarded; o_Rdata ← capture[31:0] in the cycle o_Done pulses.
- Write frames: o_Rdata unchanged.
- i_Start while o_Busy = 1: ignored, not queued.
- i_Write/i_Addr/i_Wdata changes after acceptance have no effect on the frame in flight.

## Timing
- Reset (async assert, sync deassert handled at top level) forces:
  - State IDLE.
  - o_SPI_CS_n = 1, o_SPI_Clk = 0, o_SPI_MOSI = 0.
  - o_Busy = 0, o_Done = 0, o_Rdata = 0, counters 0.
- Reset mid-frame: CS_n rises immediately (same instant as reset assertion), no o_Done, o_Rdata keeps its reset value 0.
- Acceptance at edge T:
  - At T+1: CS_n = 0, MOSI = R/W bit, o_Busy = 1.
  - First SCLK low phase begins at T+1+CS_SETUP.
- SCLK period 2·CLK_DIV; frame body 80·CLK_DIV cycles.
- After the 40th high phase:
  - SCLK low and MOSI at 0 for CLK_DIV cycles.
  - Then CS_n = 1 and o_Done = 1 for exactly one cycle.
  - o_Busy stays high for CS_IDLE further cycles.
- Total busy duration, from T+1 to the last o_Busy = 1 cycle inclusive: CS_SETUP + 81·CLK_DIV + CS_IDLE cycles.
- Back-to-back: i_Start asserted on the first cycle o_Busy = 0 is accepted; minimum CS_n high time is CS_IDLE + 1 cycles.
- MISO path latency: 2 clk (synchronizer). Sampling at end of the high phase gives ≥ CLK_DIV − 3 cycles of margin against the slave's falling-edge update.

## Structure
- Shared package spi_pkg holds:
  - FRAME_BITS = 40, ADDR_BITS = 8, DATA_BITS = 32, RW_BIT = 7 (within the address byte).
  - The master state enum.
- The existing slave is updated to import the same widths.
- One sub-module: sync_2ff, a 2-flop synchronizer with async active-low reset, used on i_SPI_MISO.
- SCLK phase counter, bit counter, and FSM live in spi_master.

## Test plan
- Write 0x80|0x02, data 0xDEADBEEF, against spi_slave → slave spi_rx pulses, spi_address_bits = 0x82, spi_data_bits = 0xDEADBEEF; o_Done exactly once.
- Read addr 1 with slave spi_reg_1 = 0x12345678 → o_Rdata = 0x12345678 on the o_Done cycle; MOSI data phase all 0.
- Read addr 0x55 (unmapped) → o_Rdata = 0xFFFFFFFF.
- Cycle-count check, CLK_DIV = 4, CS_SETUP = 4, CS_IDLE = 4 → o_Busy high 332 cycles; 40 SCLK rises; MOSI stable ±CLK_DIV around every rise.
- i_Start pulsed every cycle for 1000 cycles → frames back-to-back; each CS_n high gap ≥ 5 cycles; no frame starts while o_Busy = 1.
- i_Rst_L asserted at bit 20 of a read → CS_n = 1 and SCLK = 0 immediately; o_Done never pulses; a following write completes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared widths, state encoding and frame packing for the 40-bit SPI register protocol.
// The master and the existing slave both import these widths.
package spi_pkg;

  localparam int FRAME_BITS = 40;
  localparam int ADDR_BITS  = 8;
  localparam int DATA_BITS  = 32;
  localparam int RW_BIT     = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  // Read frames carry an all-zero data field so MOSI stays low while the slave answers.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic                 write,
    input logic [RW_BIT-1:0]    addr,
    input logic [DATA_BITS-1:0] wdata
  );
    logic [ADDR_BITS-1:0] hdr;
    hdr             = '0;
    hdr[RW_BIT]     = write;
    hdr[RW_BIT-1:0] = addr;
    return {hdr, (write ? wdata : {DATA_BITS{1'b0}})};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, cleared by an
// asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Initiator for the 40-bit SPI register protocol (mode 0, MSB first).
// One frame per accepted request; read data returned alongside a one-cycle o_Done.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | CS_n high, waiting for i_Start
// ST_SETUP | CS_n low, MOSI holds the R/W bit, CS_SETUP cycles before SCLK
// ST_SHIFT | 40 bits, each CLK_DIV cycles SCLK low then CLK_DIV high
// ST_HOLD  | SCLK and MOSI low for CLK_DIV cycles, CS_n still low
// ST_GAP   | CS_n high, o_Done on the first cycle, still busy for CS_IDLE
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_IDLE  = 4
) (
  input  logic                 clk,
  input  logic                 i_Rst_L,
  input  logic                 i_Start,
  input  logic                 i_Write,
  input  logic [RW_BIT-1:0]    i_Addr,
  input  logic [DATA_BITS-1:0] i_Wdata,
  output logic                 o_Busy,
  output logic                 o_Done,
  output logic [DATA_BITS-1:0] o_Rdata,
  output logic                 o_SPI_Clk,
  output logic                 o_SPI_MOSI,
  output logic                 o_SPI_CS_n,
  input  logic                 i_SPI_MISO
);

  if (CLK_DIV < 4) begin : g_bad_clk_div
    $error("spi_master: CLK_DIV must be at least 4 for slave oversampling");
  end

  localparam int                CNT_W      = 16;
  localparam logic [CNT_W-1:0]  DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0]  IDLE_LAST  = CNT_W'(CS_IDLE - 1);
  localparam logic [5:0]        BIT_FIRST  = 6'(FRAME_BITS - 1);

  spi_state_e              state;
  logic [CNT_W-1:0]        cnt;
  logic [5:0]              bit_cnt;
  logic [FRAME_BITS-1:0]   frame;
  logic [FRAME_BITS-1:0]   capture;
  logic                    is_write;
  logic                    miso_s;

  sync_2ff u_miso_sync (
    .clk   (clk),
    .rst_n (i_Rst_L),
    .d     (i_SPI_MISO),
    .q     (miso_s)
  );

  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      frame      <= '0;
      capture    <= '0;
      is_write   <= 1'b0;
      o_Busy     <= 1'b0;
      o_Done     <= 1'b0;
      o_Rdata    <= '0;
      o_SPI_Clk  <= 1'b0;
      o_SPI_MOSI <= 1'b0;
      o_SPI_CS_n <= 1'b1;
    end else begin
      o_Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_Start) begin
            frame      <= build_frame(i_Write, i_Addr, i_Wdata);
            is_write   <= i_Write;
            o_SPI_CS_n <= 1'b0;
            o_SPI_MOSI <= i_Write;
            o_Busy     <= 1'b1;
            cnt        <= SETUP_LAST;
            state      <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (cnt == '0) begin
            cnt     <= DIV_LAST;
            bit_cnt <= BIT_FIRST;
            state   <= ST_SHIFT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!o_SPI_Clk) begin
            o_SPI_Clk <= 1'b1;
            cnt       <= DIV_LAST;
          end else begin
            // Last cycle of the high phase: sample MISO, then open the next low phase.
            capture   <= (capture << 1) | {{(FRAME_BITS-1){1'b0}}, miso_s};
            o_SPI_Clk <= 1'b0;
            cnt       <= DIV_LAST;
            if (bit_cnt == '0) begin
              o_SPI_MOSI <= 1'b0;
              state      <= ST_HOLD;
            end else begin
              bit_cnt    <= bit_cnt - 6'd1;
              o_SPI_MOSI <= frame[FRAME_BITS-2];
              frame      <= frame << 1;
            end
          end
        end

        ST_HOLD: begin
          if (cnt == '0) begin
            o_SPI_CS_n <= 1'b1;
            o_Done     <= 1'b1;
            if (!is_write) begin
              o_Rdata <= capture[DATA_BITS-1:0];
            end
            cnt   <= IDLE_LAST;
            state <= ST_GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_GAP: begin
          if (cnt == '0) begin
            o_Busy <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master: behavioural slave with a small register map,
// a request scoreboard and protocol timing monitors.
module tb_spi_master;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 4;
  localparam int CS_IDLE  = 4;
  localparam int BUSY_LEN = CS_SETUP + 81 * CLK_DIV + CS_IDLE;

  logic        clk = 1'b0;
  logic        i_Rst_L, i_Start, i_Write, i_SPI_MISO;
  logic [6:0]  i_Addr;
  logic [31:0] i_Wdata, o_Rdata;
  logic        o_Busy, o_Done, o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_IDLE(CS_IDLE)) dut (
    .clk        (clk),
    .i_Rst_L    (i_Rst_L),
    .i_Start    (i_Start),
    .i_Write    (i_Write),
    .i_Addr     (i_Addr),
    .i_Wdata    (i_Wdata),
    .o_Busy     (o_Busy),
    .o_Done     (o_Done),
    .o_Rdata    (o_Rdata),
    .o_SPI_Clk  (o_SPI_Clk),
    .o_SPI_MOSI (o_SPI_MOSI),
    .o_SPI_CS_n (o_SPI_CS_n),
    .i_SPI_MISO (i_SPI_MISO)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural slave: 16 mapped registers, everything else reads as all ones.
  logic [31:0] slv_mem [16];
  logic [31:0] ref_mem [16];
  logic [39:0] slv_sh = '0;
  logic [39:0] slv_last = '0;
  logic [31:0] slv_word = '0;
  int          slv_bits = 0;
  int          slv_rx_cnt = 0;

  always @(negedge o_SPI_CS_n) begin
    slv_bits   = 0;
    i_SPI_MISO = 1'b1;
  end

  always @(posedge o_SPI_Clk) begin
    if (!o_SPI_CS_n) begin
      slv_sh = {slv_sh[38:0], o_SPI_MOSI};
      slv_bits++;
      if (slv_bits == 40) begin
        slv_last = slv_sh;
        slv_rx_cnt++;
        if (slv_sh[39] && slv_sh[38:32] < 7'd16) slv_mem[slv_sh[35:32]] = slv_sh[31:0];
      end
    end
  end

  always @(negedge o_SPI_Clk) begin
    if (!o_SPI_CS_n) begin
      if (slv_bits == 8) slv_word = (slv_sh[6:0] < 7'd16) ? slv_mem[slv_sh[3:0]] : 32'hFFFF_FFFF;
      if (slv_bits >= 8 && slv_bits < 40) i_SPI_MISO = slv_word[39 - slv_bits];
      else i_SPI_MISO = 1'b1;
    end
  end

  typedef struct {
    logic        write;
    logic [6:0]  addr;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_q[$];
  req_t        mon_r;
  logic [39:0] mon_ef;
  logic [31:0] exp_rdata = '0;

  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
  logic run_clean = 1'b0, had_frame = 1'b0;
  int   busy_len = 0, cs_high = 0, since_cs = 0, rises = 0, mosi_bad = 0, done_cnt = 0;
  int   min_gap = 1 << 30, max_gap = 0;

  always @(negedge clk) begin
    if (!i_Rst_L) begin
      busy_len  = 0;
      run_clean = 1'b0;
      had_frame = 1'b0;
      cs_high   = 0;
    end else begin
      if (o_Busy) busy_len++;
      else begin
        if (prev_busy && run_clean) check("busy_len", 64'(busy_len), 64'(BUSY_LEN));
        busy_len  = 0;
        run_clean = 1'b1;
      end

      if (o_SPI_CS_n) cs_high++;
      if (prev_cs && !o_SPI_CS_n) begin
        check("start_while_busy", 64'(prev_busy), 64'(0));
        check("busy_at_cs_fall", 64'(o_Busy), 64'(1));
        if (had_frame) begin
          check("cs_gap_min", 64'(cs_high >= CS_IDLE + 1), 64'(1));
          if (cs_high < min_gap) min_gap = cs_high;
          if (cs_high > max_gap) max_gap = cs_high;
        end
        if (exp_q.size() > 0) check("mosi_rw_bit", 64'(o_SPI_MOSI), 64'(exp_q[0].write));
        else check("unexpected_frame", 64'(1), 64'(0));
        had_frame = 1'b1;
        cs_high   = 0;
        since_cs  = 0;
        rises     = 0;
        mosi_bad  = 0;
      end else if (!o_SPI_CS_n) begin
        since_cs++;
      end

      if (!o_SPI_CS_n && !prev_sclk && o_SPI_Clk) begin
        if (rises == 0) check("first_rise", 64'(since_cs), 64'(CS_SETUP + CLK_DIV));
        rises++;
      end
      if (!prev_cs && (o_SPI_MOSI !== prev_mosi) && !(prev_sclk && !o_SPI_Clk)) mosi_bad++;

      if (o_Done) begin
        done_cnt++;
        check("done_single", 64'(prev_done), 64'(0));
        check("cs_at_done", 64'(o_SPI_CS_n), 64'(1));
        check("sclk_at_done", 64'(o_SPI_Clk), 64'(0));
        check("sclk_rises", 64'(rises), 64'(40));
        check("mosi_stable", 64'(mosi_bad), 64'(0));
        check("slave_rx_count", 64'(slv_rx_cnt), 64'(done_cnt));
        if (exp_q.size() == 0) begin
          check("done_without_request", 64'(1), 64'(0));
        end else begin
          mon_r  = exp_q.pop_front();
          mon_ef = {mon_r.write, mon_r.addr, (mon_r.write ? mon_r.wdata : 32'h0)};
          check("slave_frame", 64'(slv_last), 64'(mon_ef));
          if (mon_r.write) begin
            if (mon_r.addr < 7'd16) ref_mem[mon_r.addr[3:0]] = mon_r.wdata;
          end else begin
            exp_rdata = (mon_r.addr < 7'd16) ? ref_mem[mon_r.addr[3:0]] : 32'hFFFF_FFFF;
          end
          check("rdata", 64'(o_Rdata), 64'(exp_rdata));
        end
      end
    end
    prev_cs   = o_SPI_CS_n;
    prev_sclk = o_SPI_Clk;
    prev_mosi = o_SPI_MOSI;
    prev_busy = o_Busy;
    prev_done = o_Done;
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (o_Busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (o_Busy) check("idle_timeout", 64'(o_Busy), 64'(0));
  endtask

  task automatic issue(input logic w, input logic [6:0] a, input logic [31:0] d);
    req_t r;
    wait_idle(2000);
    i_Start = 1'b1;
    i_Write = w;
    i_Addr  = a;
    i_Wdata = d;
    r.write = w;
    r.addr  = a;
    r.wdata = d;
    exp_q.push_back(r);
    @(negedge clk);
    // Scramble the request inputs; the frame in flight must not notice.
    i_Start = 1'b0;
    i_Write = 1'($urandom);
    i_Addr  = 7'($urandom);
    i_Wdata = $urandom;
  endtask

  task automatic run_frame(input logic w, input logic [6:0] a, input logic [31:0] d);
    issue(w, a, d);
    @(negedge clk);
    wait_idle(2000);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int d_before;
    int n_push;
    req_t r;
    logic [31:0] v;

    i_Rst_L    = 1'b0;
    i_Start    = 1'b0;
    i_Write    = 1'b0;
    i_Addr     = '0;
    i_Wdata    = '0;
    i_SPI_MISO = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v          = $urandom;
      slv_mem[i] = v;
      ref_mem[i] = v;
    end
    slv_mem[1] = 32'h1234_5678;
    ref_mem[1] = 32'h1234_5678;

    repeat (3) @(negedge clk);
    check("reset_cs_n", 64'(o_SPI_CS_n), 64'(1));
    check("reset_sclk", 64'(o_SPI_Clk), 64'(0));
    check("reset_mosi", 64'(o_SPI_MOSI), 64'(0));
    check("reset_busy", 64'(o_Busy), 64'(0));
    check("reset_done", 64'(o_Done), 64'(0));
    check("reset_rdata", 64'(o_Rdata), 64'(0));
    i_Rst_L = 1'b1;
    @(negedge clk);

    run_frame(1'b1, 7'h02, 32'hDEAD_BEEF);
    check("write_addr_byte", 64'(slv_last[39:32]), 64'(8'h82));
    check("write_data", 64'(slv_last[31:0]), 64'(32'hDEAD_BEEF));
    check("write_done_count", 64'(done_cnt), 64'(1));
    run_frame(1'b0, 7'h01, 32'h0);
    check("read_addr1", 64'(o_Rdata), 64'(32'h1234_5678));
    run_frame(1'b0, 7'h55, 32'h0);
    check("read_unmapped", 64'(o_Rdata), 64'(32'hFFFF_FFFF));

    for (int k = 0; k < 12; k++) begin
      run_frame(1'($urandom_range(0, 1)), 7'($urandom_range(0, 19)), $urandom);
    end

    // i_Start held high with fresh random request fields every cycle.
    min_gap  = 1 << 30;
    max_gap  = 0;
    d_before = done_cnt;
    n_push   = 0;
    for (int c = 0; c < 1000; c++) begin
      i_Start = 1'b1;
      i_Write = 1'($urandom_range(0, 1));
      i_Addr  = 7'($urandom_range(0, 19));
      i_Wdata = $urandom;
      if (!o_Busy) begin
        r.write = i_Write;
        r.addr  = i_Addr;
        r.wdata = i_Wdata;
        exp_q.push_back(r);
        n_push++;
      end
      @(negedge clk);
    end
    i_Start = 1'b0;
    @(negedge clk);
    wait_idle(2000);
    check("stream_gap_min", 64'(min_gap), 64'(CS_IDLE + 1));
    check("stream_gap_max", 64'(max_gap), 64'(CS_IDLE + 1));
    check("stream_frames", 64'(done_cnt - d_before), 64'(n_push));
    check("stream_queue_empty", 64'(exp_q.size()), 64'(0));

    // Reset in the middle of a read; the preceding read left o_Rdata non-zero.
    run_frame(1'b0, 7'h55, 32'h0);
    issue(1'b0, 7'h03, 32'h0);
    n = 0;
    while (slv_bits < 20 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reached_bit20", 64'(slv_bits), 64'(20));
    #2 i_Rst_L = 1'b0;
    #1;
    check("midrst_cs_n", 64'(o_SPI_CS_n), 64'(1));
    check("midrst_sclk", 64'(o_SPI_Clk), 64'(0));
    check("midrst_busy", 64'(o_Busy), 64'(0));
    check("midrst_rdata", 64'(o_Rdata), 64'(0));
    d_before = done_cnt;
    exp_q.delete();
    exp_rdata = '0;
    repeat (3) @(negedge clk);
    i_Rst_L = 1'b1;
    repeat (20) @(negedge clk);
    check("no_done_after_reset", 64'(done_cnt), 64'(d_before));
    check("rdata_kept_zero", 64'(o_Rdata), 64'(0));

    v = $urandom;
    run_frame(1'b1, 7'h05, v);
    check("post_reset_write", 64'(slv_last[31:0]), 64'(v));
    run_frame(1'b0, 7'h05, 32'h0);
    check("post_reset_readback", 64'(o_Rdata), 64'(v));

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
